ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit beside the EX-stage ALU; executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Holds the pipeline through stallreq_o while it iterates, then presents wd_o/wdata_o for one cycle.
//  EX write-back muxes wdata_o in while valid_o is high.
// PARAMETERS
//  XLEN       32  operand/result width; must be even
//  STEP_BITS  1   quotient/multiplier bits retired per CALC cycle; 1, 2 or 4; must divide XLEN
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     synchronous reset, active-high (`RstEnable)
//  start_i     in   1     EX holds an M-extension op (OP_OP, funct7=0000001)
//  flush_i     in   1     pipeline flush; abort current operation
//  alufun3_i   in   3     funct3 select: 000 MUL .. 111 REMU
//  reg1_i      in   XLEN  rs1 operand
//  reg2_i      in   XLEN  rs2 operand
//  wd_i        in   5     destination register address
//  stallreq_o  out  1     stall request to pipeline control
//  busy_o      out  1     state is CALC or FIX
//  valid_o     out  1     result valid (state DONE)
//  wd_o        out  5     captured destination address
//  wdata_o     out  XLEN  result
// BEHAVIOUR
//  Reset: state=IDLE; valid_o=0, busy_o=0, wd_o=0, wdata_o=0, all internal registers 0.
//  State machine and transitions (N = XLEN/STEP_BITS):
//   - IDLE: start_i=1 && flush_i=0 -> latch funct3, |rs1|, |rs2|, sign flags and wd_i; go to CALC.
//   - CALC: N cycles, counter N-1..0.
//     - Multiply: shift-add into a 2*XLEN product.
//     - Divide: restoring shift-subtract, XLEN-bit quotient and remainder.
//     - Counter 0 -> FIX.
//   - FIX: apply sign correction (negate on sign mismatch; REM takes the dividend's sign).
//     - Select result: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
//     - Register the result into wdata_o; go to DONE.
//   - DONE: valid_o=1 for exactly 1 cycle; go to IDLE unconditionally.
//  Latency: start_i seen in IDLE at cycle 0 -> valid_o at cycle N+2.
//  Signedness:
//   - MULHSU treats rs1 as signed and rs2 as unsigned.
//   - *U ops take no absolute value.
//  Special cases are always forced in FIX, independent of the datapath:
//   - div by 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   - DIV with -2^(XLEN-1) / -1: DIV -> -2^(XLEN-1); REM -> 0.
//  stallreq_o (combinational) = (IDLE && start_i && !flush_i) || CALC || FIX.
//   - Deasserted in DONE, so the instruction leaves EX together with valid_o.
//  Boundary conditions:
//   - start_i while not in IDLE is ignored.
//   - start_i in DONE does not restart the op; the same instruction is still present.
//   - flush_i in CALC or FIX: IDLE next cycle, valid_o never asserts.
//   - flush_i in DONE: valid_o is still driven this cycle; the flush gates write-back.
//   - flush_i and start_i together in IDLE: stay in IDLE.
//   - rst overrides flush_i and start_i in every state.
//  wdata_o and wd_o hold their last value outside DONE.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   - In IDLE, start_i with any of the following goes IDLE -> DONE directly (latency 1) with the forced result:
//     - divisor == 0 (div/rem)
//     - signed overflow case
//     - either multiply operand == 0 (result 0)
//   - stallreq_o is high in that IDLE cycle only.
//  MULDIV_EARLY_OUT_EN undefined: every op takes the full N+2 cycles; results are identical.
// STRUCTURE
//  defines.v additions:
//   - FUNCT7_MULDIV
//   - FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU, FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU
//   - MD_IDLE/MD_CALC/MD_FIX/MD_DONE (2-bit) state encodings
//  Sub-module muldiv_step: combinational single-bit add-or-subtract step, instanced STEP_BITS times in a chain.
// TESTING (XLEN=32, STEP_BITS=1, N+2=34)
//  - MUL 7 x 0xFFFFFFFD -> wdata_o=0xFFFFFFEB, valid_o at cycle 34; stallreq_o high cycles 0..33.
//  - MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//    Latency 1 with MULDIV_EARLY_OUT_EN, 34 without.
//  - flush_i at cycle 10 of a DIV -> busy_o=0 at cycle 11, valid_o stays 0; next MUL 3x4 -> 12 at cycle 34.
//  - rst at cycle 5 of MUL -> all outputs 0 next cycle; start_i held across DONE -> exactly one valid_o pulse.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings for the iterative RV32M multiply/divide unit.
//   FUNCT7_MULDIV      funct7 value that marks an M-extension OP_OP instruction
//   FUNCT3_*           operation select carried on alufun3_i
//   md_state_e         2-bit unit state encoding (MD_IDLE/MD_CALC/MD_FIX/MD_DONE)
package ex_muldiv_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one combinational bit-step of the shared mul/div datapath.
//   is_div   1     1 = restoring divide step, 0 = shift-add multiply step
//   hi       XLEN  upper accumulator (partial product high / partial remainder)
//   lo       XLEN  lower register (multiplier+product low / dividend+quotient)
//   op       XLEN  multiplicand or divisor (magnitude)
//   hi_n     XLEN  next upper accumulator
//   lo_n     XLEN  next lower register
module ex_muldiv_step
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] op,
   output logic [XLEN-1:0] hi_n,
   output logic [XLEN-1:0] lo_n
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      // Multiply consumes multiplier bits LSB first and shifts the product right.
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, op} : '0);
      // Divide brings in dividend bits MSB first; partial remainder < divisor,
      // so the shifted value fits in XLEN+1 bits and diff[XLEN] is the borrow.
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, op};
      if (is_div) begin
         hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
      end else begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on operand magnitudes, stalls
// the pipeline while iterating, then presents the result for one cycle.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// zero-operand multiplies skip straight from IDLE to DONE.
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start_i, flush_i      M-op present in EX / pipeline flush (abort)
//   alufun3_i             funct3 operation select
//   reg1_i, reg2_i        rs1 / rs2 operands
//   wd_i                  destination register address
//   stallreq_o            stall request to pipeline control (combinational)
//   busy_o                unit is in CALC or FIX
//   valid_o               result valid (DONE, one cycle)
//   wd_o, wdata_o         captured destination address and result
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int STEP_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      alufun3_i,
   input  logic [XLEN-1:0] reg1_i,
   input  logic [XLEN-1:0] reg2_i,
   input  logic [4:0]      wd_i,
   output logic            stallreq_o,
   output logic            busy_o,
   output logic            valid_o,
   output logic [4:0]      wd_o,
   output logic [XLEN-1:0] wdata_o
);

   localparam int N     = XLEN / STEP_BITS;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   md_state_e         state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   hi_q, lo_q, op_q;
   logic              neg_q, neg_r;
   logic              force_en;
   logic [XLEN-1:0]   force_res;
   logic [4:0]        wd_q;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   // Operand decode for the op being started in IDLE.
   logic            rs1_signed, rs2_signed, sa, sb;
   logic            div0, ovf, force_en_d, early;
   logic [XLEN-1:0] force_res_d;

   always_comb begin
      rs1_signed  = (alufun3_i == FUNCT3_MULH) || (alufun3_i == FUNCT3_MULHSU) ||
                    (alufun3_i == FUNCT3_DIV)  || (alufun3_i == FUNCT3_REM);
      rs2_signed  = (alufun3_i == FUNCT3_MULH) || (alufun3_i == FUNCT3_DIV) ||
                    (alufun3_i == FUNCT3_REM);
      sa          = rs1_signed & reg1_i[XLEN-1];
      sb          = rs2_signed & reg2_i[XLEN-1];
      div0        = alufun3_i[2] && (reg2_i == '0);
      ovf         = ((alufun3_i == FUNCT3_DIV) || (alufun3_i == FUNCT3_REM)) &&
                    (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (reg2_i == '1);
      force_en_d  = div0 || ovf;
      force_res_d = '0;
      if (div0)
         force_res_d = alufun3_i[1] ? reg1_i : '1;
      else if (ovf)
         force_res_d = alufun3_i[1] ? '0 : reg1_i;
`ifdef MULDIV_EARLY_OUT_EN
      early = force_en_d || (!alufun3_i[2] && ((reg1_i == '0) || (reg2_i == '0)));
`else
      early = 1'b0;
`endif
   end

   // Chain of STEP_BITS single-bit steps retired per CALC cycle.
   logic [XLEN-1:0] hi_c [0:STEP_BITS];
   logic [XLEN-1:0] lo_c [0:STEP_BITS];

   assign hi_c[0] = hi_q;
   assign lo_c[0] = lo_q;

   for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
      ex_muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div (funct3_q[2]),
         .hi     (hi_c[g]),
         .lo     (lo_c[g]),
         .op     (op_q),
         .hi_n   (hi_c[g+1]),
         .lo_n   (lo_c[g+1])
      );
   end

   // Sign correction and result select, used in FIX.
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   calc_res;

   always_comb begin
      prod = neg_if2({hi_q, lo_q}, neg_q);
      case (funct3_q)
         FUNCT3_MUL:                calc_res = prod[XLEN-1:0];
         FUNCT3_MULH, FUNCT3_MULHSU,
         FUNCT3_MULHU:              calc_res = prod[2*XLEN-1:XLEN];
         FUNCT3_DIV, FUNCT3_DIVU:   calc_res = neg_if(lo_q, neg_q);
         default:                   calc_res = neg_if(hi_q, neg_r);
      endcase
   end

   assign stallreq_o = ((state == MD_IDLE) && start_i && !flush_i) ||
                       (state == MD_CALC) || (state == MD_FIX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= MD_IDLE;
         cnt       <= '0;
         funct3_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         force_en  <= 1'b0;
         force_res <= '0;
         wd_q      <= '0;
         busy_o    <= 1'b0;
         valid_o   <= 1'b0;
         wd_o      <= '0;
         wdata_o   <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start_i && !flush_i) begin
                  funct3_q  <= alufun3_i;
                  hi_q      <= '0;
                  lo_q      <= neg_if(reg1_i, sa);
                  op_q      <= neg_if(reg2_i, sb);
                  neg_q     <= sa ^ sb;
                  neg_r     <= sa;
                  force_en  <= force_en_d;
                  force_res <= force_res_d;
                  wd_q      <= wd_i;
                  if (early) begin
                     state   <= MD_DONE;
                     valid_o <= 1'b1;
                     wd_o    <= wd_i;
                     wdata_o <= force_res_d;
                  end else begin
                     state  <= MD_CALC;
                     busy_o <= 1'b1;
                     cnt    <= CNT_W'(N - 1);
                  end
               end
            end
            MD_CALC: begin
               if (flush_i) begin
                  state  <= MD_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  hi_q <= hi_c[STEP_BITS];
                  lo_q <= lo_c[STEP_BITS];
                  if (cnt == '0)
                     state <= MD_FIX;
                  else
                     cnt <= cnt - 1'b1;
               end
            end
            MD_FIX: begin
               busy_o <= 1'b0;
               if (flush_i) begin
                  state <= MD_IDLE;
               end else begin
                  state   <= MD_DONE;
                  valid_o <= 1'b1;
                  wd_o    <= wd_q;
                  wdata_o <= force_en ? force_res : calc_res;
               end
            end
            default: begin
               // DONE always retires; a flush here is handled by write-back gating.
               state   <= MD_IDLE;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv (XLEN=32, STEP_BITS=1).
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_SP = 1;
`else
   localparam int LAT_SP = 34;
`endif
   localparam int LAT = 34;

   logic        clk = 1'b0;
   logic        rst, start_i, flush_i;
   logic [2:0]  alufun3_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        stallreq_o, busy_o, valid_o;
   logic [4:0]  wd_o;
   logic [31:0] wdata_o;

   int n_chk  = 0;
   int n_pass = 0;

   ex_muldiv #(.XLEN(32), .STEP_BITS(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .flush_i    (flush_i),
      .alufun3_i  (alufun3_i),
      .reg1_i     (reg1_i),
      .reg2_i     (reg2_i),
      .wd_i       (wd_i),
      .stallreq_o (stallreq_o),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .wd_o       (wd_o),
      .wdata_o    (wdata_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op at cycle 0 and hold start_i until valid_o (pipeline stalled),
   // dropping it in the DONE cycle as the instruction leaves EX.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, output logic [31:0] res, output int lat,
                         output logic stall_ok);
      alufun3_i = f; reg1_i = a; reg2_i = b; wd_i = wd; start_i = 1'b1;
      #1;
      stall_ok = stallreq_o;
      lat = 0;
      while (!valid_o && lat < 100) begin
         tick();
         lat++;
         if (!valid_o) stall_ok &= stallreq_o;
      end
      res = wdata_o;
      stall_ok &= !stallreq_o;
      start_i = 1'b0;
      tick();
   endtask

   task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int          lat;
      logic        st;
      run_op(f, a, b, 5'd7, res, lat, st);
      chk(tag, res, exp);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      logic        st;
      int          pulses;

      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      alufun3_i = '0; reg1_i = '0; reg2_i = '0; wd_i = '0;
      tick(); tick();
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_wd", 32'(wd_o), 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_stall", 32'(stallreq_o), 32'd0);
      rst = 1'b0;
      tick();

      // MUL with latency, stall window and destination check
      run_op(FUNCT3_MUL, 32'd7, 32'hFFFFFFFD, 5'd17, res, lat, st);
      chk("mul", res, 32'hFFFFFFEB);
      chk("mul_lat", 32'(lat), 32'd34);
      chk("mul_stall", 32'(st), 32'd1);
      chk("mul_wd", 32'(wd_o), 32'd17);
      tick();
      chk("mul_hold", wdata_o, 32'hFFFFFFEB);
      chk("mul_vld_low", 32'(valid_o), 32'd0);

      op_check("mulh",   FUNCT3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT);
      op_check("mulhu",  FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);
      op_check("mulhsu", FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT);
      op_check("mulh_neg", FUNCT3_MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, LAT);
      op_check("div",    FUNCT3_DIV,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT);
      op_check("rem",    FUNCT3_REM,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT);
      op_check("divu",   FUNCT3_DIVU,   32'd100, 32'd7, 32'd14, LAT);
      op_check("remu",   FUNCT3_REMU,   32'd100, 32'd7, 32'd2, LAT);
      op_check("div_nn", FUNCT3_DIV,    32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, LAT);
      op_check("divu0",  FUNCT3_DIVU,   32'd5, 32'd0, 32'hFFFFFFFF, LAT_SP);
      op_check("remu0",  FUNCT3_REMU,   32'd5, 32'd0, 32'd5, LAT_SP);
      op_check("div0s",  FUNCT3_DIV,    32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, LAT_SP);
      op_check("rem0s",  FUNCT3_REM,    32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, LAT_SP);
      op_check("div_ovf", FUNCT3_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SP);
      op_check("rem_ovf", FUNCT3_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0, LAT_SP);
      op_check("mul_zero", FUNCT3_MUL,  32'd0, 32'd5, 32'd0, LAT_SP);

      // flush at cycle 10 of a DIV
      alufun3_i = FUNCT3_DIV; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd4; start_i = 1'b1;
      repeat (10) tick();
      flush_i = 1'b1; start_i = 1'b0;
      tick();
      flush_i = 1'b0;
      chk("flush_busy", 32'(busy_o), 32'd0);
      chk("flush_stall", 32'(stallreq_o), 32'd0);
      pulses = 0;
      repeat (40) begin
         if (valid_o) pulses++;
         tick();
      end
      chk("flush_novalid", 32'(pulses), 32'd0);
      op_check("mul_after_flush", FUNCT3_MUL, 32'd3, 32'd4, 32'd12, LAT);

      // flush and start together in IDLE stays idle
      alufun3_i = FUNCT3_MUL; reg1_i = 32'd2; reg2_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
      tick();
      start_i = 1'b0; flush_i = 1'b0;
      chk("flush_start_busy", 32'(busy_o), 32'd0);
      tick();

      // rst at cycle 5 of MUL
      alufun3_i = FUNCT3_MUL; reg1_i = 32'd9; reg2_i = 32'd9; wd_i = 5'd3; start_i = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("rst5_busy", 32'(busy_o), 32'd0);
      chk("rst5_valid", 32'(valid_o), 32'd0);
      chk("rst5_wd", 32'(wd_o), 32'd0);
      chk("rst5_wdata", wdata_o, 32'd0);
      rst = 1'b0; start_i = 1'b0;
      tick();

      // start_i held through DONE: one valid pulse only
      alufun3_i = FUNCT3_MUL; reg1_i = 32'd6; reg2_i = 32'd7; wd_i = 5'd9; start_i = 1'b1;
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         if (valid_o) begin
            pulses++;
            chk("hold_res", wdata_o, 32'd42);
            tick();
            start_i = 1'b0;
         end else begin
            tick();
         end
      end
      start_i = 1'b0;
      chk("hold_pulses", 32'(pulses), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
